// File: rtl/div_pkg.sv
// Shared constants and state type for the 16-by-8 sequential restoring divider.
package div_pkg;

  localparam int DW   = 16;
  localparam int VW   = 8;
  localparam int ITER = DW;

  localparam logic [DW-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem,
  input  logic          q_msb,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] diff;

  always_comb begin
    trial    = {rem, q_msb};
    diff     = trial - {1'b0, divisor};
    q_bit    = (trial >= {1'b0, divisor});
    // rem < divisor on entry, so a successful subtract always fits in VW bits
    rem_next = q_bit ? diff[VW-1:0] : trial[VW-1:0];
  end

endmodule

// File: rtl/seq_div_16by8.sv
// Iterative restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
module seq_div_16by8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  import div_pkg::*;

  localparam int CW = $clog2(DW);

  state_t        state;
  logic [DW-1:0] q_work;
  logic [VW-1:0] r_work;
  logic [VW-1:0] dvs;
  logic [CW-1:0] count;
  logic [VW-1:0] r_next;
  logic          q_bit;

  div_step #(.VW(VW)) u_step (
    .rem      (r_work),
    .q_msb    (q_work[DW-1]),
    .divisor  (dvs),
    .rem_next (r_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      q_work      <= '0;
      r_work      <= '0;
      dvs         <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            dvs  <= divisor;
            if (divisor == '0) begin
              quotient    <= DIV0_QUOT;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              q_work      <= dividend;
              r_work      <= '0;
              count       <= CW'(ITER - 1);
              state       <= CALC;
            end
          end
        end
        CALC: begin
          q_work <= {q_work[DW-2:0], q_bit};
          r_work <= r_next;
          count  <= count - 1'b1;
          // final iteration publishes its own step result directly to the outputs
          if (count == '0) begin
            quotient  <= {q_work[DW-2:0], q_bit};
            remainder <= r_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8: arithmetic reference model plus directed and swept vectors.
module tb_seq_div_16by8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned done_cnt;

  seq_div_16by8 #(.DW(16), .VW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: results from plain / and %, timing as "accept, 16 busy cycles, done".
  logic [1:0]  m_phase;   // 0 idle, 1 computing, 2 result cycle
  int          m_left;
  logic        m_busy, m_done, m_dz;
  logic [15:0] m_q, m_pq;
  logic [7:0]  m_r, m_pr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 2'd0; m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_q <= '0; m_r <= '0; m_pq <= '0; m_pr <= '0;
    end else begin
      case (m_phase)
        2'd0: if (start) begin
          m_busy <= 1'b1;
          if (divisor == 8'd0) begin
            m_q <= 16'hFFFF; m_r <= dividend[7:0]; m_dz <= 1'b1; m_done <= 1'b1; m_phase <= 2'd2;
          end else begin
            m_dz <= 1'b0;
            m_pq <= dividend / 16'(divisor);
            m_pr <= 8'(dividend % 16'(divisor));
            m_left <= 16; m_phase <= 2'd1;
          end
        end
        2'd1: if (m_left == 1) begin
          m_phase <= 2'd2; m_done <= 1'b1; m_q <= m_pq; m_r <= m_pr;
        end else m_left <= m_left - 1;
        default: begin
          m_done <= 1'b0; m_busy <= 1'b0; m_phase <= 2'd0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_dz", 32'(div_by_zero), 32'(m_dz));
    chk("cyc_quot", 32'(quotient), 32'(m_q));
    chk("cyc_rem", 32'(remainder), 32'(m_r));
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Returns cycles from accept edge to done visibility, counted so divide-by-zero = 1.
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat);
    @(posedge clk); #1;
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int unsigned snap;
    logic [7:0]  a, b;
    logic [15:0] dvd;
    logic [31:0] recon;

    n_checks = 0; n_pass = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    rst_n = 1'b1;

    run_op(16'd100, 8'd7, lat);
    chk("100/7_lat", 32'(lat), 32'd17);
    chk("100/7_q", 32'(quotient), 32'd14);
    chk("100/7_r", 32'(remainder), 32'd2);
    chk("100/7_dz", 32'(div_by_zero), 32'd0);
    chk("100/7_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("100/7_done_drop", 32'(done), 32'd0);
    chk("100/7_busy_drop", 32'(busy), 32'd0);

    run_op(16'd65535, 8'd255, lat);
    chk("65535/255_q", 32'(quotient), 32'd257);
    chk("65535/255_r", 32'(remainder), 32'd0);
    run_op(16'd65535, 8'd1, lat);
    chk("65535/1_q", 32'(quotient), 32'hFFFF);
    chk("65535/1_r", 32'(remainder), 32'd0);
    run_op(16'd5, 8'd200, lat);
    chk("5/200_q", 32'(quotient), 32'd0);
    chk("5/200_r", 32'(remainder), 32'd5);

    run_op(16'h04D2, 8'd0, lat);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_dz", 32'(div_by_zero), 32'd1);
    chk("div0_q", 32'(quotient), 32'hFFFF);
    chk("div0_r", 32'(remainder), 32'hD2);
    run_op(16'd10, 8'd3, lat);
    chk("10/3_dz", 32'(div_by_zero), 32'd0);
    chk("10/3_q", 32'(quotient), 32'd3);
    chk("10/3_r", 32'(remainder), 32'd1);

    // second request arrives mid-computation and must be dropped
    @(posedge clk); #1;
    snap = done_cnt;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 7;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd17);
    chk("ign_q", 32'(quotient), 32'd111);
    chk("ign_r", 32'(remainder), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("ign_one_done", 32'(done_cnt - snap), 32'd1);

    // asynchronous reset in cycle 8 of a computation
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd1000; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dz", 32'(div_by_zero), 32'd0);
    chk("arst_quot", 32'(quotient), 32'd0);
    chk("arst_rem", 32'(remainder), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    snap = done_cnt;
    repeat (25) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt - snap), 32'd0);
    run_op(16'd1000, 8'd9, lat);
    chk("post_rst_lat", 32'(lat), 32'd17);
    chk("post_rst_q", 32'(quotient), 32'd111);
    chk("post_rst_r", 32'(remainder), 32'd1);

    // start held high: back-to-back operations, tracked cycle by cycle by the model
    @(posedge clk); #1;
    start = 1'b1; dividend = 16'd12345; divisor = 8'd100;
    repeat (60) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 1500; i++) begin
      if (i % 2 == 0) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
        dvd = 16'(a) * 16'(b);
      end else begin
        a = 8'd0;
        b = 8'($urandom_range(1, 255));
        dvd = 16'($urandom_range(0, 65535));
      end
      run_op(dvd, b, lat);
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      chk("sweep_recon", recon, 32'(dvd));
      chk("sweep_rem_lt", 32'(remainder < b), 32'd1);
      if (i % 2 == 0) begin
        chk("prod_q", 32'(quotient), 32'(a));
        chk("prod_r", 32'(remainder), 32'd0);
      end
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
